// File: rtl/recip_nr_if.sv
// Operand/result handshake bundle for the Newton-Raphson reciprocal refiner.
// slave = refiner side, master = producer/consumer side.
`timescale 1ns/1ps
interface recip_nr_if #(
    parameter int NSIG = 11
) ();
    logic            in_valid;
    logic            in_ready;
    logic [NSIG-1:0] in_mant;
    logic            out_valid;
    logic            out_ready;
    logic [NSIG+1:0] result;

    modport slave  (input  in_valid, in_mant, out_ready,
                    output in_ready, out_valid, result);
    modport master (output in_valid, in_mant, out_ready,
                    input  in_ready, out_valid, result);
endinterface

// File: rtl/recip_nr.sv
// Sequential Newton-Raphson reciprocal refiner (x <- x*(2 - d*x)) on one shared multiplier.
// Optional RECIP_NR_POW2_BYPASS_EN: d = 1.0 skips the iterations and finishes straight from SEED.
`timescale 1ns/1ps
module recip_nr #(
    parameter int NEXP  = 5,
    parameter int NSIG  = 11,
    parameter int NITER = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    recip_nr_if.slave       bus,
    output logic [9:0]      lut_idx,
    input  logic [NSIG+1:0] seed_in
);
    localparam int FW = NSIG - 1;   // stored fraction of d
    localparam int XW = NSIG + 2;   // x, Q1.(NSIG+1)
    localparam int EW = NSIG + 3;   // e, Q2.(NSIG+1)
    localparam int PW = XW + EW;

    localparam logic [XW-1:0] X_ONE = {1'b1, {(NSIG+1){1'b0}}};
    localparam logic [EW-1:0] E_TWO = {2'b10, {(NSIG+1){1'b0}}};
    localparam logic [PW-1:0] P_ONE = PW'(X_ONE);

    if (NITER < 1 || NITER > 3 || NEXP < 1 || NSIG < 11) begin : g_bad_cfg
        $error("recip_nr: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, SEED, MUL_E, MUL_X, DONE} state_t;

    state_t         state, state_nx;
    logic [FW-1:0]  frac;
    logic [XW-1:0]  x;
    logic [EW-1:0]  e;
    logic [1:0]     cnt;
    logic           accept, last_iter, bypass, sel_d;
    logic [EW-1:0]  mul_a, e_nx;
    logic [PW-1:0]  prod, xq;
    logic [XW-1:0]  x_nx;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_iter = (cnt == 2'(NITER - 1));

`ifdef RECIP_NR_POW2_BYPASS_EN
    assign bypass = (frac == '0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SEED;
            SEED:    state_nx = bypass ? DONE : MUL_E;
            MUL_E:   state_nx = MUL_X;
            MUL_X:   state_nx = last_iter ? DONE : MUL_E;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        sel_d         = (state == MUL_E);
    end

    // Shared multiplier: d*x in MUL_E, x*e in MUL_X.
    always_comb begin
        mul_a = sel_d ? EW'({1'b1, frac}) : e;
        prod  = PW'(mul_a) * PW'(x);
        e_nx  = E_TWO - EW'(prod >> (NSIG - 1));
        xq    = prod >> (NSIG + 1);
        x_nx  = (xq > P_ONE) ? X_ONE : XW'(xq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac <= '0;
            x    <= '0;
            e    <= '0;
            cnt  <= '0;
        end else begin
            if (accept) frac <= FW'(bus.in_mant);
            case (state)
                SEED: begin
                    x   <= bypass ? X_ONE : seed_in;
                    cnt <= '0;
                end
                MUL_E: e <= e_nx;
                MUL_X: begin
                    x <= x_nx;
                    if (!last_iter) cnt <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign lut_idx    = 10'(frac >> (FW - 10));
    assign bus.result = x;
endmodule

// File: doc/recip_nr.md
# recip_nr

Sequential Newton-Raphson reciprocal refiner for the half-precision divide path (NEXP=5, NSIG=11). It takes a normalized significand, drives the 10-bit index into the reciprocal seed ROM, and samples the returned seed. It then runs NITER iterations of x ← x·(2 − d·x) on one shared multiplier and returns 1/d in the same fixed-point format as the seed. It sits between operand unpacking and the final quotient multiply.

## Interface
- NEXP, 5, exponent width (carried for consistency; unused internally)
- NSIG, 11, significand width including hidden bit
- NITER, 2, Newton-Raphson iterations (1..3)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  high only in IDLE
- in_mant  in  NSIG  significand d, Q1.(NSIG-1); bit NSIG-1 (hidden) is ignored and treated as 1
- lut_idx  out  10  seed ROM index = registered in_mant[NSIG-2:NSIG-11]
- seed_in  in  NSIG+2  seed from ROM, Q1.(NSIG+1), combinational from lut_idx
- out_valid  out  1  result valid (DONE)
- out_ready  in  1  consumer accepts result
- result  out  NSIG+2  1/d, Q1.(NSIG+1)

## Operation
- States: IDLE, SEED, MUL_E, MUL_X, DONE; iteration counter 0..NITER-1.
- IDLE: in_valid && in_ready → capture d = {1, in_mant[NSIG-2:0]}, → SEED.
- SEED: x ← seed_in, count ← 0, → MUL_E.
- MUL_E: p = d·x (Q2.(2NSIG)), truncated to Q2.(NSIG+1); e ← 2 − p, NSIG+3 bits unsigned, → MUL_X.
- MUL_X: x ← (x·e) truncated to Q1.(NSIG+1); if integer bit set and any fraction bit set, clamp to 1.0 (13'h1000 at NSIG=11). If count == NITER-1 → DONE, else count++ and → MUL_E.
- DONE: result = x, out_valid = 1; out_valid && out_ready → IDLE. result holds until the next SEED.
- Only one multiplier exists, used in MUL_E and MUL_X.
- No input/output overlap: a new operand is not accepted in the handshake cycle of DONE.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, lut_idx 0, counter 0.
- rst_n asserted mid-operation aborts immediately; no result is emitted and the block is in IDLE after deassertion.

## Timing
- Accept edge = E0. Seed is sampled at E1. Each iteration is 2 edges.
- out_valid rises after edge E(1+2·NITER): 5 edges for NITER=2.
- lut_idx is stable from the edge after E0 until the next accept.
- seed_in must settle within the SEED cycle; the ROM is combinational.
- in_ready falls the cycle after accept. It rises the cycle after the out handshake.
- out_valid stays high and result stays stable under out_ready=0 indefinitely.

## Configuration
- RECIP_NR_POW2_BYPASS_EN defined:
  - In SEED, if the fraction is zero (d = 1.0), x ← 1.0 and the FSM goes directly to DONE.
  - out_valid rises after E1.
- Undefined: the all-zero fraction takes the full iteration path with latency 1+2·NITER. The result is still exactly 1.0, because the seed is 1.0 and e = 1.0 exactly.

## Test plan
- The bench models the seed ROM behaviourally; NITER=2 unless noted.
- in_mant=11'h400 (d=1.0) → result 13'h1000. Latency is 5 edges without the macro and 1 edge with it.
- in_mant=11'h600 (d=1.5) → result 13'h0AAA ±1 LSB after 5 edges; lut_idx=10'h200 during SEED.
- in_mant=11'h7FF (d≈1.999) → result 13'h0801 ±1 LSB; no clamp taken.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result and out_valid stable, in_ready=0, a new in_valid is ignored. Raising out_ready → in_ready=1 on the next cycle.
- Reset mid-op: assert rst_n=0 in MUL_X → out_valid=0, result=0, in_ready=1 after release. The next operand 11'h600 yields 13'h0AAA normally.
- Sweep: all 1024 fractions back-to-back → every result within 1 LSB of the reference 4096/d. out_valid pulses once per operand.
